// File: rtl/axi_4_pkg.sv
`default_nettype none
// ============================================================================
// Module   : axi_4_pkg
// Purpose  : Shared types and constants for the AXI4 master-port arbiter.
//            - axi_4_arb_states_e : arbiter FSM state encoding
//            - c_TIMEOUT_CYCLES_DEFAULT : default watchdog limit per grant
// Revision : 1.0 - initial release
// ============================================================================
package axi_4_pkg;

   localparam int unsigned c_TIMEOUT_CYCLES_DEFAULT = 1024;

   typedef enum logic [1:0] {
      ARB_IDLE    = 2'd0,
      ARB_ISSUE   = 2'd1,
      ARB_WAIT_RD = 2'd2,
      ARB_WAIT_WR = 2'd3
   } axi_4_arb_states_e;

endpackage
`default_nettype wire

// File: rtl/axi_4_rr_picker.sv
`default_nettype none
// ============================================================================
// Module   : axi_4_rr_picker
// Purpose  : Combinational round-robin picker. The requester just after
//            last_grant has highest priority, wrapping around at NUM_REQ.
// Ports    : req        - request vector (one bit per requester)
//            last_grant - index of the most recently served requester
//            winner     - one-hot winner, all-zero when req is all-zero
// Revision : 1.0 - initial release
// ============================================================================
module axi_4_rr_picker
   import axi_4_pkg::*;
#(
   parameter int NUM_REQ = 2,
   parameter int LG_W    = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [LG_W-1:0]    last_grant,
   output logic [NUM_REQ-1:0] winner
);

   int w_dist;
   int w_best_dist;
   int w_best_idx;

   // Each requester gets a distance from the slot after last_grant; the
   // smallest distance among active requesters wins. NUM_REQ means "none".
   always_comb begin
      w_dist      = 0;
      w_best_dist = NUM_REQ;
      w_best_idx  = 0;
      for (int i = 0; i < NUM_REQ; i++) begin
         w_dist = i - int'(last_grant) - 1;
         if (w_dist < 0) begin
            w_dist = w_dist + NUM_REQ;
         end
         if (req[i] && (w_dist < w_best_dist)) begin
            w_best_dist = w_dist;
            w_best_idx  = i;
         end
      end
      winner = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         winner[i] = (w_best_dist < NUM_REQ) && (i == w_best_idx);
      end
   end

endmodule
`default_nettype wire

// File: rtl/axi_4_master_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : axi_4_master_arbiter
// Purpose  : Shares one AXI4 master controller between NUM_REQ requesters.
//            Grants round-robin, issues a one-cycle ld_req/st_req start
//            pulse, then waits for the read-last or write-response handshake
//            and pulses done to the owner. A watchdog flags transactions that
//            wait TIMEOUT_CYCLES cycles without aborting them.
// Ports    : clk, reset (async, active low)
//            req_ld, req_st        - per-requester level requests
//            grant, done           - one-hot owner / completion pulse
//            ld_req, st_req        - start pulses to the master controller
//            s_rvalid, m_rready, s_rlast, s_bvalid, m_bready - handshakes
//            busy, err_timeout     - status (err_timeout is sticky)
// Revision : 1.0 - initial release
// ============================================================================
module axi_4_master_arbiter
   import axi_4_pkg::*;
#(
   parameter int NUM_REQ        = 2,
   parameter int TIMEOUT_CYCLES = c_TIMEOUT_CYCLES_DEFAULT
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [NUM_REQ-1:0] req_ld,
   input  logic [NUM_REQ-1:0] req_st,
   output logic [NUM_REQ-1:0] grant,
   output logic [NUM_REQ-1:0] done,
   output logic               ld_req,
   output logic               st_req,
   input  logic               s_rvalid,
   input  logic               m_rready,
   input  logic               s_rlast,
   input  logic               s_bvalid,
   input  logic               m_bready,
   output logic               busy,
   output logic               err_timeout
);

   localparam int LG_W = $clog2(NUM_REQ);
   localparam int WD_W = $clog2(TIMEOUT_CYCLES) + 1;
   localparam logic [WD_W-1:0] c_WDOG_MAX = WD_W'(TIMEOUT_CYCLES);

   axi_4_arb_states_e r_state;
   logic [NUM_REQ-1:0] r_grant;
   logic               r_ld_req;
   logic               r_st_req;
   logic               r_err;
   logic [WD_W-1:0]    r_wdog;
   logic [LG_W-1:0]    r_last_grant;

   logic [NUM_REQ-1:0] w_winner;
   logic               w_req_any;
   logic               w_win_ld;
   logic               w_hs_rd;
   logic               w_hs_wr;
   logic               w_done_any;
   logic [LG_W-1:0]    w_owner_idx;
   logic [WD_W-1:0]    w_wdog_next;

   axi_4_rr_picker #(
      .NUM_REQ (NUM_REQ),
      .LG_W    (LG_W)
   ) u_picker (
      .req        (req_ld | req_st),
      .last_grant (r_last_grant),
      .winner     (w_winner)
   );

   assign w_req_any = |(req_ld | req_st);
   // Load wins over store when the winner has both raised.
   assign w_win_ld  = |(req_ld & w_winner);

   // Completion is only recognised in the matching wait state, so handshakes
   // seen while idle or issuing never produce a done pulse.
   assign w_hs_rd    = (r_state == ARB_WAIT_RD) && s_rvalid && m_rready && s_rlast;
   assign w_hs_wr    = (r_state == ARB_WAIT_WR) && s_bvalid && m_bready;
   assign w_done_any = w_hs_rd || w_hs_wr;

   assign w_wdog_next = (r_wdog == c_WDOG_MAX) ? r_wdog : r_wdog + 1'b1;

   always_comb begin
      w_owner_idx = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (r_grant[i]) begin
            w_owner_idx = LG_W'(i);
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state      <= ARB_IDLE;
         r_grant      <= '0;
         r_ld_req     <= 1'b0;
         r_st_req     <= 1'b0;
         r_err        <= 1'b0;
         r_wdog       <= '0;
         r_last_grant <= LG_W'(NUM_REQ - 1);
      end else begin
         case (r_state)
            ARB_IDLE: begin
               if (w_req_any) begin
                  r_grant  <= w_winner;
                  r_ld_req <= w_win_ld;
                  r_st_req <= !w_win_ld;
                  r_state  <= ARB_ISSUE;
               end
            end
            ARB_ISSUE: begin
               // The registered start pulse doubles as the op flag here.
               r_ld_req <= 1'b0;
               r_st_req <= 1'b0;
               r_wdog   <= '0;
               r_state  <= r_ld_req ? ARB_WAIT_RD : ARB_WAIT_WR;
            end
            ARB_WAIT_RD, ARB_WAIT_WR: begin
               // Watchdog only reports; the transaction keeps waiting.
               r_wdog <= w_wdog_next;
               if (w_wdog_next == c_WDOG_MAX) begin
                  r_err <= 1'b1;
               end
               if (w_done_any) begin
                  r_grant      <= '0;
                  r_last_grant <= w_owner_idx;
                  r_state      <= ARB_IDLE;
               end
            end
            default: begin
               r_state <= ARB_IDLE;
            end
         endcase
      end
   end

   assign grant       = r_grant;
   assign done        = r_grant & {NUM_REQ{w_done_any}};
   assign ld_req      = r_ld_req;
   assign st_req      = r_st_req;
   assign busy        = (r_state != ARB_IDLE);
   assign err_timeout = r_err;

endmodule
`default_nettype wire

// File: tb/tb_axi_4_master_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_axi_4_master_arbiter
// Purpose  : Self-checking bench for axi_4_master_arbiter (NUM_REQ=3,
//            TIMEOUT_CYCLES=16). Cycle table, directed sequences and random
//            transactions checked against a transaction-level round-robin
//            model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_axi_4_master_arbiter;

   localparam int N   = 3;
   localparam int TMO = 16;

   logic         clk = 1'b0;
   logic         reset;
   logic [N-1:0] req_ld, req_st;
   logic [N-1:0] grant, done;
   logic         ld_req, st_req, busy, err_timeout;
   logic         s_rvalid, m_rready, s_rlast, s_bvalid, m_bready;

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   axi_4_master_arbiter #(
      .NUM_REQ        (N),
      .TIMEOUT_CYCLES (TMO)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .req_ld      (req_ld),
      .req_st      (req_st),
      .grant       (grant),
      .done        (done),
      .ld_req      (ld_req),
      .st_req      (st_req),
      .s_rvalid    (s_rvalid),
      .m_rready    (m_rready),
      .s_rlast     (s_rlast),
      .s_bvalid    (s_bvalid),
      .m_bready    (m_bready),
      .busy        (busy),
      .err_timeout (err_timeout)
   );

   typedef struct {
      logic [N-1:0] ld, st;
      logic         rv, rr, rl, bv, br;
      logic [N-1:0] e_grant, e_done;
      logic         e_ld, e_st, e_busy;
   } vec_t;

   vec_t tbl[16];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic next_cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_hs();
      s_rvalid = 1'b0; m_rready = 1'b0; s_rlast = 1'b0;
      s_bvalid = 1'b0; m_bready = 1'b0;
   endtask

   function automatic logic rbit(input bit en);
      return en && ($urandom_range(0, 1) == 1);
   endfunction

   function automatic vec_t mk(input logic [N-1:0] ld, st, input logic [4:0] hs,
                               input logic [N-1:0] g, d, input logic [2:0] o);
      vec_t v;
      v.ld = ld; v.st = st;
      {v.rv, v.rr, v.rl, v.bv, v.br} = hs;
      v.e_grant = g; v.e_done = d;
      {v.e_ld, v.e_st, v.e_busy} = o;
      return v;
   endfunction

   // Reference: first active requester searching upward from last+1 with wrap.
   function automatic int rr_pick(input logic [N-1:0] r, input int last);
      for (int k = 1; k <= N; k++) begin
         int i;
         i = (last + k) % N;
         if (r[i]) return i;
      end
      return -1;
   endfunction

   task automatic chk_quiet(input string tag);
      chk({tag, " grant"}, grant, 0);
      chk({tag, " done"}, done, 0);
      chk({tag, " ld_req"}, ld_req, 0);
      chk({tag, " st_req"}, st_req, 0);
      chk({tag, " busy"}, busy, 0);
      chk({tag, " err_timeout"}, err_timeout, 0);
   endtask

   // Assert reset mid-cycle, check outputs at once, release after a clock.
   task automatic do_reset();
      @(negedge clk);
      #1 reset = 1'b0;
      #1 chk_quiet("reset");
      req_ld = '0; req_st = '0; clear_hs();
      next_cyc();
      reset = 1'b1;
   endtask

   // Called in an idle cycle with requests already driven. Checks the issue
   // cycle, `beats` wait cycles (completion on the last), and the idle cycle.
   task automatic do_txn(input logic [N-1:0] eg, input bit is_ld, input int beats,
                         input bit noise, input bit drop);
      next_cyc();
      clear_hs();
      if (noise) begin
         {s_rvalid, m_rready, s_rlast, s_bvalid, m_bready} = 5'($urandom);
      end
      @(negedge clk);
      chk("issue grant", grant, eg);
      chk("issue ld_req", ld_req, is_ld);
      chk("issue st_req", st_req, !is_ld);
      chk("issue done", done, 0);
      for (int b = 1; b <= beats; b++) begin
         next_cyc();
         if (drop && b == 1) begin
            req_ld = req_ld & ~eg;
            req_st = req_st & ~eg;
         end
         if (is_ld) begin
            if (b == beats) {s_rvalid, m_rready, s_rlast} = 3'b111;
            else if (noise) begin
               s_rvalid = rbit(1'b1); m_rready = rbit(1'b1);
               s_rlast  = !(s_rvalid && m_rready) && rbit(1'b1);
            end else {s_rvalid, m_rready, s_rlast} = 3'b110;
            s_bvalid = rbit(noise); m_bready = rbit(noise);
         end else begin
            if (b == beats) {s_bvalid, m_bready} = 2'b11;
            else begin
               s_bvalid = noise ? rbit(1'b1) : 1'b1;
               m_bready = 1'b0;
            end
            s_rvalid = rbit(noise); m_rready = rbit(noise); s_rlast = rbit(noise);
         end
         @(negedge clk);
         chk($sformatf("wait%0d done", b), done, (b == beats) ? eg : '0);
         chk($sformatf("wait%0d start pulse", b), {ld_req, st_req}, 0);
         chk($sformatf("wait%0d busy", b), busy, 1);
      end
      next_cyc();
      clear_hs();
      @(negedge clk);
      chk("after grant", grant, 0);
      chk("after busy", busy, 0);
      chk("after done", done, 0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL global time limit: bench still running at t=%0t, expected finish", $time);
      $fatal(1);
   end

   initial begin
      int last;
      logic [N-1:0] rl, rs, eg;
      int w;

      // ---- cycle table: single load with 4 beats, ignored handshakes, then
      //      load-before-store for a requester raising both ----
      //            ld      st      rv rr rl bv br  grant   done    ld st busy
      tbl[0]  = mk(3'b001, 3'b000, 5'b00000, 3'b000, 3'b000, 3'b000);
      tbl[1]  = mk(3'b001, 3'b000, 5'b11100, 3'b001, 3'b000, 3'b101);
      tbl[2]  = mk(3'b001, 3'b000, 5'b11000, 3'b001, 3'b000, 3'b001);
      tbl[3]  = mk(3'b001, 3'b000, 5'b11000, 3'b001, 3'b000, 3'b001);
      tbl[4]  = mk(3'b000, 3'b000, 5'b11000, 3'b001, 3'b000, 3'b001);
      tbl[5]  = mk(3'b000, 3'b000, 5'b11100, 3'b001, 3'b001, 3'b001);
      tbl[6]  = mk(3'b000, 3'b000, 5'b11100, 3'b000, 3'b000, 3'b000);
      tbl[7]  = mk(3'b000, 3'b000, 5'b11111, 3'b000, 3'b000, 3'b000);
      tbl[8]  = mk(3'b001, 3'b001, 5'b00000, 3'b000, 3'b000, 3'b000);
      tbl[9]  = mk(3'b001, 3'b001, 5'b00011, 3'b001, 3'b000, 3'b101);
      tbl[10] = mk(3'b001, 3'b001, 5'b11111, 3'b001, 3'b001, 3'b001);
      tbl[11] = mk(3'b000, 3'b001, 5'b00000, 3'b000, 3'b000, 3'b000);
      tbl[12] = mk(3'b000, 3'b001, 5'b11111, 3'b001, 3'b000, 3'b011);
      tbl[13] = mk(3'b000, 3'b001, 5'b00010, 3'b001, 3'b000, 3'b001);
      tbl[14] = mk(3'b000, 3'b001, 5'b11111, 3'b001, 3'b001, 3'b001);
      tbl[15] = mk(3'b000, 3'b000, 5'b00000, 3'b000, 3'b000, 3'b000);

      reset = 1'b1;
      req_ld = '0; req_st = '0;
      clear_hs();
      #2 reset = 1'b0;
      repeat (2) @(posedge clk);
      #1 chk_quiet("power-on reset");
      reset = 1'b1;

      for (int r = 0; r < 16; r++) begin
         next_cyc();
         req_ld = tbl[r].ld; req_st = tbl[r].st;
         {s_rvalid, m_rready, s_rlast, s_bvalid, m_bready} =
            {tbl[r].rv, tbl[r].rr, tbl[r].rl, tbl[r].bv, tbl[r].br};
         @(negedge clk);
         chk($sformatf("row%0d grant", r), grant, tbl[r].e_grant);
         chk($sformatf("row%0d done", r), done, tbl[r].e_done);
         chk($sformatf("row%0d ld_req", r), ld_req, tbl[r].e_ld);
         chk($sformatf("row%0d st_req", r), st_req, tbl[r].e_st);
         chk($sformatf("row%0d busy", r), busy, tbl[r].e_busy);
         chk($sformatf("row%0d err_timeout", r), err_timeout, 0);
      end

      // ---- two requesters held: round robin 001, 010, 001 from reset ----
      do_reset();
      req_ld = 3'b011;
      do_txn(3'b001, 1'b1, 2, 1'b0, 1'b0);
      do_txn(3'b010, 1'b1, 1, 1'b0, 1'b0);
      do_txn(3'b001, 1'b1, 3, 1'b0, 1'b0);
      req_ld = '0;
      next_cyc();
      @(negedge clk);
      chk("rr idle busy", busy, 0);

      // ---- reset while waiting on read data abandons the owner ----
      do_reset();
      req_ld = 3'b001;
      next_cyc();
      next_cyc();
      {s_rvalid, m_rready, s_rlast} = 3'b110;
      @(negedge clk);
      chk("pre-reset busy", busy, 1);
      #1 s_rlast = 1'b1; reset = 1'b0;
      #1 chk_quiet("mid-txn reset");
      clear_hs();
      next_cyc();
      reset = 1'b1;
      req_ld = 3'b010;
      do_txn(3'b010, 1'b1, 2, 1'b0, 1'b0);

      // ---- random transactions against the round-robin model ----
      do_reset();
      last = N - 1;
      for (int t = 0; t < 150; t++) begin
         if ($urandom_range(0, 7) == 0) begin
            req_ld = '0; req_st = '0;
            next_cyc();
            @(negedge clk);
            chk("rand idle busy", busy, 0);
            chk("rand idle grant", grant, 0);
            continue;
         end
         rl = N'($urandom_range(0, (1 << N) - 1));
         rs = N'($urandom_range(0, (1 << N) - 1));
         if ((rl | rs) == '0) rs[$urandom_range(0, N - 1)] = 1'b1;
         req_ld = rl; req_st = rs;
         w = rr_pick(rl | rs, last);
         eg = '0;
         eg[w] = 1'b1;
         do_txn(eg, rl[w], $urandom_range(1, 6), 1'b1, ($urandom_range(0, 1) == 1));
         last = w;
         chk("rand err_timeout", err_timeout, 0);
      end

      // ---- watchdog: store never acknowledged ----
      // The counter reaches 16 at the close of the 16th wait cycle; the sticky
      // flag is visible from then on while the arbiter keeps waiting.
      do_reset();
      req_st = 3'b010;
      next_cyc();
      @(negedge clk);
      chk("wd issue st_req", st_req, 1);
      chk("wd issue grant", grant, 3'b010);
      for (int c = 1; c <= 20; c++) begin
         next_cyc();
         @(negedge clk);
         chk($sformatf("wd cycle%0d err_timeout", c), err_timeout, (c >= 17));
         chk($sformatf("wd cycle%0d busy", c), busy, 1);
         chk($sformatf("wd cycle%0d grant", c), grant, 3'b010);
         chk($sformatf("wd cycle%0d done", c), done, 0);
      end
      next_cyc();
      s_bvalid = 1'b1; m_bready = 1'b1;
      @(negedge clk);
      chk("wd late done", done, 3'b010);
      next_cyc();
      clear_hs();
      req_st = '0;
      @(negedge clk);
      chk("wd idle busy", busy, 0);
      chk("wd sticky err", err_timeout, 1);
      do_reset();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
`default_nettype wire
